// File: rtl/emu_trace_buf.sv
// emu_trace_buf: decimated probe capture into an on-chip buffer, started by a
// trigger after arming, then streamed back to the host over valid/ready.
// Everything runs on emu_clk. emu_rst asserts asynchronously and is released
// synchronously through a two-flop synchroniser.
module emu_trace_buf #(
  parameter int DEC_BITS  = 8,
  parameter int DATA_W    = 32,
  parameter int ADDR_BITS = 10
) (
  input  logic                 emu_clk,
  input  logic                 emu_rst,
  input  logic [DEC_BITS-1:0]  emu_dec_thr,
  input  logic                 arm,
  input  logic                 trig,
  input  logic [DATA_W-1:0]    din,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_last,
  output logic [1:0]           state,
  output logic [ADDR_BITS:0]   sample_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t                st;
  logic                  rst_meta;
  logic                  rst_sync;
  logic [ADDR_BITS-1:0]  wr_ptr;
  logic [DEC_BITS-1:0]   dec_cnt;
  logic [DEC_BITS-1:0]   thr_lat;
  logic [ADDR_BITS:0]    rd_ptr;
  logic                  vld_p1;
  logic                  last_p1;
  logic [DATA_W-1:0]     data_p1;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic wr_en;
  logic wr_last;
  logic pop;
  logic out_free;
  logic move_p1;
  logic issue;

  // Decimation counter step: counts 0..thr and wraps back to 0.
  function automatic logic [DEC_BITS-1:0] dec_next(input logic [DEC_BITS-1:0] cnt,
                                                   input logic [DEC_BITS-1:0] thr);
    return (cnt == thr) ? '0 : cnt + 1'b1;
  endfunction

  assign state = st;

  // Trigger-cycle write is sample 0; later writes happen whenever the counter sits at 0.
  assign wr_en    = ((st == S_ARMED) && trig) || ((st == S_CAPTURE) && (dec_cnt == '0));
  assign wr_last  = (wr_ptr == {ADDR_BITS{1'b1}});
  assign pop      = rd_valid & rd_ready;
  assign out_free = ~rd_valid | rd_ready;
  assign move_p1  = (st == S_READOUT) & vld_p1 & out_free;
  // Keep the RAM read register full: refill when empty or being drained this cycle.
  assign issue    = (st == S_READOUT) & ~rd_ptr[ADDR_BITS] & (~vld_p1 | move_p1);

  // Reset synchroniser: immediate assertion, release aligned to emu_clk.
  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      rst_meta <= 1'b1;
      rst_sync <= 1'b1;
    end else begin
      rst_meta <= 1'b0;
      rst_sync <= rst_meta;
    end
  end

  // Buffer write port and registered read port (p0 address -> p1 data).
  always_ff @(posedge emu_clk) begin
    if (wr_en) mem[wr_ptr] <= din;
    if (issue) data_p1 <= mem[rd_ptr[ADDR_BITS-1:0]];
  end

  // Control FSM with capture bookkeeping and the readout skid/output stage.
  always_ff @(posedge emu_clk or posedge rst_sync) begin
    if (rst_sync) begin
      st           <= S_IDLE;
      wr_ptr       <= '0;
      sample_count <= '0;
      dec_cnt      <= '0;
      thr_lat      <= '0;
      rd_ptr       <= '0;
      vld_p1       <= 1'b0;
      last_p1      <= 1'b0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      rd_data      <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (arm) begin
            st           <= S_ARMED;
            wr_ptr       <= '0;
            sample_count <= '0;
            rd_ptr       <= '0;
            vld_p1       <= 1'b0;
          end
        end
        S_ARMED: begin
          if (trig) begin
            thr_lat      <= emu_dec_thr;
            dec_cnt      <= dec_next('0, emu_dec_thr);
            wr_ptr       <= wr_ptr + 1'b1;
            sample_count <= sample_count + 1'b1;
            st           <= wr_last ? S_READOUT : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          dec_cnt <= dec_next(dec_cnt, thr_lat);
          if (wr_en) begin
            wr_ptr       <= wr_ptr + 1'b1;
            sample_count <= sample_count + 1'b1;
            if (wr_last) st <= S_READOUT;
          end
        end
        S_READOUT: begin
          // p0 -> p1: read issue into the RAM output register
          if (issue) begin
            rd_ptr  <= rd_ptr + 1'b1;
            vld_p1  <= 1'b1;
            last_p1 <= (rd_ptr[ADDR_BITS-1:0] == {ADDR_BITS{1'b1}});
          end else if (move_p1) begin
            vld_p1 <= 1'b0;
          end
          // p1 -> output register presented to the host
          if (move_p1) begin
            rd_valid <= 1'b1;
            rd_data  <= data_p1;
            rd_last  <= last_p1;
          end else if (out_free) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
          end
          if (pop && rd_last) begin
            st       <= S_IDLE;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_ptr   <= '0;
            vld_p1   <= 1'b0;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_emu_trace_buf.sv
// Directed bench for emu_trace_buf: a 16-deep instance for the main scenarios
// and a 4-deep instance for the maximum decimation gap.
module tb_emu_trace_buf;

  logic        clk = 1'b0;
  logic        emu_rst = 1'b1;
  logic [7:0]  thr = 8'd0;
  logic        arm = 1'b0;
  logic        trig = 1'b0;
  logic        rd_ready = 1'b0;
  logic [31:0] din = 32'd0;

  logic        rd_valid4, rd_last4;
  logic [31:0] rd_data4;
  logic [1:0]  state4;
  logic [4:0]  sample_count4;

  logic        rd_valid2, rd_last2;
  logic [31:0] rd_data2;
  logic [1:0]  state2;
  logic [2:0]  sample_count2;

  int tests = 0;
  int fails = 0;
  logic [31:0] dec_t0;

  always #5 clk = ~clk;

  emu_trace_buf #(.DEC_BITS(8), .DATA_W(32), .ADDR_BITS(4)) u_dut4 (
    .emu_clk(clk), .emu_rst(emu_rst), .emu_dec_thr(thr), .arm(arm), .trig(trig),
    .din(din), .rd_valid(rd_valid4), .rd_ready(rd_ready), .rd_data(rd_data4),
    .rd_last(rd_last4), .state(state4), .sample_count(sample_count4)
  );

  emu_trace_buf #(.DEC_BITS(8), .DATA_W(32), .ADDR_BITS(2)) u_dut2 (
    .emu_clk(clk), .emu_rst(emu_rst), .emu_dec_thr(thr), .arm(arm), .trig(trig),
    .din(din), .rd_valid(rd_valid2), .rd_ready(rd_ready), .rd_data(rd_data2),
    .rd_last(rd_last2), .state(state2), .sample_count(sample_count2)
  );

  // One clock: land just after the falling edge; din advances by one per cycle.
  task automatic tick;
    @(negedge clk);
    #1;
    din = din + 32'd1;
  endtask

  task automatic apply_reset;
    emu_rst = 1'b1; arm = 1'b0; trig = 1'b0;
    tick; tick;
    emu_rst = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_reset;
    emu_rst = 1'b1;
    tick;
    tests++; if (state4 !== 2'd0) begin fails++; $display("FAIL reset_state4 got %0d want 0", state4); end
    tests++; if (sample_count4 !== 5'd0) begin fails++; $display("FAIL reset_count4 got %0d want 0", sample_count4); end
    tests++; if (rd_valid4 !== 1'b0 || rd_last4 !== 1'b0) begin fails++; $display("FAIL reset_valid_last4 got %b%b want 00", rd_valid4, rd_last4); end
    tests++; if (rd_data4 !== 32'd0) begin fails++; $display("FAIL reset_data4 got %0h want 0", rd_data4); end
    tests++; if (state2 !== 2'd0 || sample_count2 !== 3'd0 || rd_valid2 !== 1'b0 || rd_last2 !== 1'b0 || rd_data2 !== 32'd0) begin
      fails++; $display("FAIL reset_dut2 got st=%0d cnt=%0d v=%b l=%b d=%0h want all 0", state2, sample_count2, rd_valid2, rd_last2, rd_data2);
    end
    emu_rst = 1'b0;
    tick; tick; tick;
    tests++; if (state4 !== 2'd0 || rd_valid4 !== 1'b0) begin fails++; $display("FAIL reset_release got st=%0d v=%b want 0 0", state4, rd_valid4); end
  endtask

  task automatic test_full_rate;
    logic [31:0] t0;
    int n, k, idx, bub;
    apply_reset;
    thr = 8'd0; rd_ready = 1'b1;
    arm = 1'b1; tick; arm = 1'b0;
    tests++; if (state4 !== 2'd1) begin fails++; $display("FAIL fr_armed got %0d want 1", state4); end
    trig = 1'b1; t0 = din; tick; trig = 1'b0; n = 1;
    tests++; if (state4 !== 2'd2 || sample_count4 !== 5'd1) begin fails++; $display("FAIL fr_first got st=%0d cnt=%0d want 2 1", state4, sample_count4); end
    while (state4 !== 2'd3 && n < 100) begin tick; n++; end
    tests++; if (n != 16) begin fails++; $display("FAIL fr_capture_len got %0d want 16", n); end
    tests++; if (sample_count4 !== 5'd16) begin fails++; $display("FAIL fr_count got %0d want 16", sample_count4); end
    idx = 0; k = 0; bub = 0;
    while (idx < 16 && k < 100) begin
      tick; k++;
      if (rd_valid4) begin
        if (idx == 0) begin
          tests++; if (k > 2) begin fails++; $display("FAIL fr_latency got %0d want <=2", k); end
        end
        tests++; if (rd_data4 !== 32'(t0 + idx)) begin fails++; $display("FAIL fr_data%0d got %0h want %0h", idx, rd_data4, 32'(t0 + idx)); end
        tests++; if (rd_last4 !== (idx == 15)) begin fails++; $display("FAIL fr_last%0d got %b want %b", idx, rd_last4, (idx == 15)); end
        idx++;
      end else if (idx > 0) bub++;
    end
    tests++; if (idx != 16) begin fails++; $display("FAIL fr_words got %0d want 16", idx); end
    tests++; if (bub != 0) begin fails++; $display("FAIL fr_bubbles got %0d want 0", bub); end
    tick;
    tests++; if (rd_valid4 !== 1'b0 || state4 !== 2'd0 || sample_count4 !== 5'd16) begin
      fails++; $display("FAIL fr_done got v=%b st=%0d cnt=%0d want 0 0 16", rd_valid4, state4, sample_count4);
    end
  endtask

  task automatic test_decimation;
    int n;
    apply_reset;
    thr = 8'd3; rd_ready = 1'b0;
    arm = 1'b1; tick; arm = 1'b0;
    trig = 1'b1; dec_t0 = din; tick; trig = 1'b0; n = 1;
    thr = 8'd3;
    while (state4 !== 2'd3 && n < 200) begin
      tick; n++;
      if (n == 10) thr = 8'd0;
      if (n == 5) begin
        tests++; if (sample_count4 !== 5'd2) begin fails++; $display("FAIL dec_count_at5 got %0d want 2", sample_count4); end
      end
      if (n == 13) begin
        tests++; if (sample_count4 !== 5'd4) begin fails++; $display("FAIL dec_count_at13 got %0d want 4", sample_count4); end
      end
    end
    tests++; if (n != 61) begin fails++; $display("FAIL dec_capture_len got %0d want 61", n); end
    tests++; if (sample_count4 !== 5'd16) begin fails++; $display("FAIL dec_count got %0d want 16", sample_count4); end
  endtask

  // Drains the record captured by test_decimation under a 1,0,0,1 ready pattern.
  task automatic test_stall;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int i, idx;
    logic pv, pr, pl;
    logic [31:0] pd;
    i = 0; idx = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 32'd0;
    while (idx < 16 && i < 200) begin
      if (pv && !pr) begin
        tests++; if (rd_valid4 !== 1'b1 || rd_data4 !== pd || rd_last4 !== pl) begin
          fails++; $display("FAIL stall_hold got v=%b d=%0h l=%b want 1 %0h %b", rd_valid4, rd_data4, rd_last4, pd, pl);
        end
      end
      rd_ready = pat[i % 4];
      if (rd_valid4 && rd_ready) begin
        tests++; if (rd_data4 !== 32'(dec_t0 + 4 * idx)) begin fails++; $display("FAIL stall_data%0d got %0h want %0h", idx, rd_data4, 32'(dec_t0 + 4 * idx)); end
        tests++; if (rd_last4 !== (idx == 15)) begin fails++; $display("FAIL stall_last%0d got %b want %b", idx, rd_last4, (idx == 15)); end
        idx++;
      end
      pv = rd_valid4; pr = rd_ready; pd = rd_data4; pl = rd_last4;
      tick; i++;
    end
    tests++; if (idx != 16) begin fails++; $display("FAIL stall_transfers got %0d want 16", idx); end
    tests++; if (rd_valid4 !== 1'b0 || state4 !== 2'd0) begin fails++; $display("FAIL stall_done got v=%b st=%0d want 0 0", rd_valid4, state4); end
    rd_ready = 1'b0;
  endtask

  task automatic test_arm_trig_same;
    logic [31:0] t0;
    int n, k, idx;
    apply_reset;
    thr = 8'd0; rd_ready = 1'b1;
    arm = 1'b1; trig = 1'b1; tick; arm = 1'b0; trig = 1'b0;
    tests++; if (state4 !== 2'd1) begin fails++; $display("FAIL at_armed got %0d want 1", state4); end
    tick; tick; tick;
    tests++; if (state4 !== 2'd1 || sample_count4 !== 5'd0) begin fails++; $display("FAIL at_nocapture got st=%0d cnt=%0d want 1 0", state4, sample_count4); end
    trig = 1'b1; t0 = din; tick; trig = 1'b0; n = 1;
    tests++; if (state4 !== 2'd2 || sample_count4 !== 5'd1) begin fails++; $display("FAIL at_start got st=%0d cnt=%0d want 2 1", state4, sample_count4); end
    while (state4 !== 2'd3 && n < 100) begin tick; n++; end
    tests++; if (n != 16) begin fails++; $display("FAIL at_capture_len got %0d want 16", n); end
    idx = 0; k = 0;
    while (idx < 16 && k < 100) begin
      tick; k++;
      if (rd_valid4) begin
        tests++; if (rd_data4 !== 32'(t0 + idx)) begin fails++; $display("FAIL at_data%0d got %0h want %0h", idx, rd_data4, 32'(t0 + idx)); end
        idx++;
      end
    end
    tests++; if (idx != 16) begin fails++; $display("FAIL at_words got %0d want 16", idx); end
  endtask

  task automatic test_reset_mid_capture;
    logic [31:0] t1;
    int n, k, idx;
    apply_reset;
    thr = 8'd0; rd_ready = 1'b1;
    arm = 1'b1; tick; arm = 1'b0;
    trig = 1'b1; tick; trig = 1'b0; n = 1;
    while (sample_count4 !== 5'd7 && n < 50) begin tick; n++; end
    tests++; if (sample_count4 !== 5'd7 || state4 !== 2'd2) begin fails++; $display("FAIL rm_reach7 got cnt=%0d st=%0d want 7 2", sample_count4, state4); end
    emu_rst = 1'b1;
    #1;
    tests++; if (state4 !== 2'd0 || sample_count4 !== 5'd0) begin fails++; $display("FAIL rm_async got st=%0d cnt=%0d want 0 0", state4, sample_count4); end
    tests++; if (rd_valid4 !== 1'b0 || rd_last4 !== 1'b0 || rd_data4 !== 32'd0) begin fails++; $display("FAIL rm_async_out got v=%b l=%b d=%0h want 0 0 0", rd_valid4, rd_last4, rd_data4); end
    tick; tick;
    emu_rst = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (rd_valid4 !== 1'b0 || state4 !== 2'd0) k++;
    end
    tests++; if (k != 0) begin fails++; $display("FAIL rm_no_readout got %0d bad cycles want 0", k); end
    arm = 1'b1; tick; arm = 1'b0;
    trig = 1'b1; t1 = din; tick; trig = 1'b0; n = 1;
    while (state4 !== 2'd3 && n < 100) begin tick; n++; end
    tests++; if (n != 16 || sample_count4 !== 5'd16) begin fails++; $display("FAIL rm_recapture got len=%0d cnt=%0d want 16 16", n, sample_count4); end
    idx = 0; k = 0;
    while (idx < 16 && k < 100) begin
      tick; k++;
      if (rd_valid4) begin
        tests++; if (rd_data4 !== 32'(t1 + idx)) begin fails++; $display("FAIL rm_data%0d got %0h want %0h", idx, rd_data4, 32'(t1 + idx)); end
        idx++;
      end
    end
    tests++; if (idx != 16) begin fails++; $display("FAIL rm_words got %0d want 16", idx); end
  endtask

  task automatic test_max_gap;
    logic [31:0] t0;
    int n, k, idx;
    apply_reset;
    thr = 8'd255; rd_ready = 1'b1;
    arm = 1'b1; tick; arm = 1'b0;
    trig = 1'b1; t0 = din; tick; trig = 1'b0; n = 1;
    tests++; if (sample_count2 !== 3'd1 || state2 !== 2'd2) begin fails++; $display("FAIL mg_first got cnt=%0d st=%0d want 1 2", sample_count2, state2); end
    while (state2 !== 2'd3 && n < 1000) begin
      tick; n++;
      if (n == 256) begin
        tests++; if (sample_count2 !== 3'd1) begin fails++; $display("FAIL mg_count_at256 got %0d want 1", sample_count2); end
      end
      if (n == 257) begin
        tests++; if (sample_count2 !== 3'd2) begin fails++; $display("FAIL mg_count_at257 got %0d want 2", sample_count2); end
      end
      if (n == 513) begin
        tests++; if (sample_count2 !== 3'd3) begin fails++; $display("FAIL mg_count_at513 got %0d want 3", sample_count2); end
      end
    end
    tests++; if (n != 769 || sample_count2 !== 3'd4) begin fails++; $display("FAIL mg_readout_entry got tick=%0d cnt=%0d want 769 4", n, sample_count2); end
    idx = 0; k = 0;
    while (idx < 4 && k < 50) begin
      tick; k++;
      if (rd_valid2) begin
        tests++; if (rd_data2 !== 32'(t0 + 256 * idx)) begin fails++; $display("FAIL mg_data%0d got %0h want %0h", idx, rd_data2, 32'(t0 + 256 * idx)); end
        tests++; if (rd_last2 !== (idx == 3)) begin fails++; $display("FAIL mg_last%0d got %b want %b", idx, rd_last2, (idx == 3)); end
        idx++;
      end
    end
    tests++; if (idx != 4) begin fails++; $display("FAIL mg_words got %0d want 4", idx); end
    tick;
    tests++; if (state2 !== 2'd0 || rd_valid2 !== 1'b0) begin fails++; $display("FAIL mg_done got st=%0d v=%b want 0 0", state2, rd_valid2); end
  endtask

  initial begin
    test_reset;
    test_full_rate;
    test_decimation;
    test_stall;
    test_arm_trig_same;
    test_reset_mid_capture;
    test_max_gap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
